// File: rtl/mastermind_pkg.sv
// mastermind_pkg: shared widths, counts and defaults for the Mastermind datapath.
package mastermind_pkg;
  localparam int COLOR_W = 3;
  localparam int NUM_PEGS = 4;
  localparam int NUM_COLORS = 2 ** COLOR_W;
  localparam int MAX_GUESSES = 8;
  typedef logic [COLOR_W-1:0] color_t;
  typedef logic [2:0] peg_cnt_t;
endpackage

// File: rtl/white_peg_counter.sv
// white_peg_counter: white pegs as the sum over colours of min(code_hist, guess_hist).
module white_peg_counter
  import mastermind_pkg::*;
#(
  parameter int N = NUM_COLORS
) (
  input  logic [N-1:0][2:0] code_hist,
  input  logic [N-1:0][2:0] guess_hist,
  output logic [2:0]        white
);
  always_comb begin
    white = 3'd0;
    for (int c = 0; c < N; c++)
      white = white + ((code_hist[c] < guess_hist[c]) ? code_hist[c] : guess_hist[c]);
  end
endmodule

// File: rtl/mastermind_datapath.sv
// mastermind_datapath: holds code and guess, scores one peg per compare cycle,
// and publishes black/white counts, win and game-over on reach_result_4.
module mastermind_datapath
  import mastermind_pkg::*;
#(
  parameter int COLOR_W = mastermind_pkg::COLOR_W,
  parameter int MAX_GUESSES = mastermind_pkg::MAX_GUESSES
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [COLOR_W-1:0] data_in,
  input  logic               load_code_1,
  input  logic               load_code_2,
  input  logic               load_code_3,
  input  logic               load_code_4,
  input  logic               load_guess_1,
  input  logic               load_guess_2,
  input  logic               load_guess_3,
  input  logic               load_guess_4,
  input  logic               compare,
  input  logic [1:0]         compare_i,
  input  logic               reach_result_4,
  output logic [2:0]         black_count,
  output logic [2:0]         white_count,
  output logic               result_valid,
  output logic               win,
  output logic [3:0]         guess_count,
  output logic               game_over
);
  localparam int NC = 2 ** COLOR_W;
  localparam logic [3:0] MAX_G = 4'(MAX_GUESSES);

  logic [NUM_PEGS-1:0][COLOR_W-1:0] code, guess;
  logic [NC-1:0][2:0] code_hist, guess_hist, code_nx, guess_nx;
  logic [2:0] black_acc, black_nx, white_sum;
  logic [3:0] load_code, load_guess, gc_inc;
  logic hit, fresh, win_nx;

  assign load_code = {load_code_4, load_code_3, load_code_2, load_code_1};
  assign load_guess = {load_guess_4, load_guess_3, load_guess_2, load_guess_1};
  assign gc_inc = guess_count + 4'd1;
  assign win_nx = black_acc == 3'd4;

  // Index 0 opens a new scoring pass, so the old totals are dropped before the update.
  always_comb begin
    fresh = compare_i == 2'd0;
    hit = code[compare_i] == guess[compare_i];
    black_nx = (fresh ? 3'd0 : black_acc) + {2'b00, hit};
    code_nx = fresh ? '0 : code_hist;
    guess_nx = fresh ? '0 : guess_hist;
    if (!hit) begin
      code_nx[code[compare_i]] = code_nx[code[compare_i]] + 3'd1;
      guess_nx[guess[compare_i]] = guess_nx[guess[compare_i]] + 3'd1;
    end
  end

  white_peg_counter #(.N(NC)) u_white (
    .code_hist (code_hist),
    .guess_hist(guess_hist),
    .white     (white_sum)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      code <= '0;
      guess <= '0;
      black_acc <= '0;
      code_hist <= '0;
      guess_hist <= '0;
      black_count <= '0;
      white_count <= '0;
      result_valid <= 1'b0;
      win <= 1'b0;
      guess_count <= '0;
      game_over <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      for (int k = 0; k < NUM_PEGS; k++) begin
        if (load_code[k]) code[k] <= data_in;
        if (load_guess[k] && !game_over) guess[k] <= data_in;
      end
      if (compare && !game_over) begin
        black_acc <= black_nx;
        code_hist <= code_nx;
        guess_hist <= guess_nx;
      end
      if (reach_result_4 && !game_over) begin
        black_count <= black_acc;
        white_count <= white_sum;
        result_valid <= 1'b1;
        win <= win_nx;
        guess_count <= (gc_inc >= MAX_G) ? MAX_G : gc_inc;
        game_over <= win_nx || (gc_inc == MAX_G);
      end
      // A new secret starts a new game, overriding any same-cycle finalise.
      if (|load_code) begin
        win <= 1'b0;
        game_over <= 1'b0;
        guess_count <= '0;
      end
    end
  end
endmodule

// File: tb/tb_mastermind_datapath.sv
// tb_mastermind_datapath: table of scored guesses plus hand sequences for
// game-over lockout, asynchronous reset mid-pass and compare/finalise overlap.
module tb_mastermind_datapath;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic [2:0] data_in = '0;
  logic [3:0] lc = '0, lg = '0;
  logic compare = 1'b0, reach = 1'b0;
  logic [1:0] ci = '0;
  logic [2:0] black_count, white_count;
  logic result_valid, win, game_over;
  logic [3:0] guess_count;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  mastermind_datapath dut (
    .clk           (clk),
    .resetn        (resetn),
    .data_in       (data_in),
    .load_code_1   (lc[0]),
    .load_code_2   (lc[1]),
    .load_code_3   (lc[2]),
    .load_code_4   (lc[3]),
    .load_guess_1  (lg[0]),
    .load_guess_2  (lg[1]),
    .load_guess_3  (lg[2]),
    .load_guess_4  (lg[3]),
    .compare       (compare),
    .compare_i     (ci),
    .reach_result_4(reach),
    .black_count   (black_count),
    .white_count   (white_count),
    .result_valid  (result_valid),
    .win           (win),
    .guess_count   (guess_count),
    .game_over     (game_over)
  );

  typedef struct packed {
    logic        new_code;
    logic [11:0] code;
    logic [11:0] guess;
    logic [2:0]  b;
    logic [2:0]  w;
    logic        win;
    logic [3:0]  gc;
    logic        go;
  } vec_t;

  vec_t v[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Pegs are packed as octal digits, peg 0 in the most significant digit.
  task automatic load_pegs(input bit is_code, input logic [11:0] p);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      data_in = p[3*(3-k) +: 3];
      lc = is_code ? 4'(1 << k) : 4'd0;
      lg = is_code ? 4'd0 : 4'(1 << k);
    end
    @(negedge clk);
    lc = '0;
    lg = '0;
  endtask

  task automatic score();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      compare = 1'b1;
      ci = 2'(i);
    end
    @(negedge clk);
    compare = 1'b0;
    reach = 1'b1;
    @(negedge clk);
    reach = 1'b0;
  endtask

  task automatic chk_outs(input string name, input logic [2:0] b, input logic [2:0] w,
                          input logic wn, input logic [3:0] gc, input logic go);
    chk({name, ".black"}, 32'(black_count), 32'(b));
    chk({name, ".white"}, 32'(white_count), 32'(w));
    chk({name, ".win"}, 32'(win), 32'(wn));
    chk({name, ".guess_count"}, 32'(guess_count), 32'(gc));
    chk({name, ".game_over"}, 32'(game_over), 32'(go));
  endtask

  initial begin
    v[0]  = '{1'b1, 12'o1234, 12'o1234, 3'd4, 3'd0, 1'b1, 4'd1, 1'b1};
    v[1]  = '{1'b1, 12'o1234, 12'o4321, 3'd0, 3'd4, 1'b0, 4'd1, 1'b0};
    v[2]  = '{1'b1, 12'o1122, 12'o1215, 3'd1, 3'd2, 1'b0, 4'd1, 1'b0};
    v[3]  = '{1'b0, 12'o1122, 12'o1215, 3'd1, 3'd2, 1'b0, 4'd2, 1'b0};
    v[4]  = '{1'b1, 12'o1234, 12'o5670, 3'd0, 3'd0, 1'b0, 4'd1, 1'b0};
    v[5]  = '{1'b0, 12'o1234, 12'o1111, 3'd1, 3'd0, 1'b0, 4'd2, 1'b0};
    v[6]  = '{1'b0, 12'o1234, 12'o2143, 3'd0, 3'd4, 1'b0, 4'd3, 1'b0};
    v[7]  = '{1'b0, 12'o1234, 12'o1243, 3'd2, 3'd2, 1'b0, 4'd4, 1'b0};
    v[8]  = '{1'b0, 12'o1234, 12'o1235, 3'd3, 3'd0, 1'b0, 4'd5, 1'b0};
    v[9]  = '{1'b0, 12'o1234, 12'o4444, 3'd1, 3'd0, 1'b0, 4'd6, 1'b0};
    v[10] = '{1'b0, 12'o1234, 12'o2200, 3'd1, 3'd0, 1'b0, 4'd7, 1'b0};
    v[11] = '{1'b0, 12'o1234, 12'o3412, 3'd0, 3'd4, 1'b0, 4'd8, 1'b1};

    #12;
    chk_outs("reset", 3'd0, 3'd0, 1'b0, 4'd0, 1'b0);
    chk("reset.result_valid", 32'(result_valid), 32'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int n = 0; n < 12; n++) begin
      if (v[n].new_code) load_pegs(1'b1, v[n].code);
      load_pegs(1'b0, v[n].guess);
      score();
      chk($sformatf("vec%0d.result_valid", n), 32'(result_valid), 32'd1);
      chk_outs($sformatf("vec%0d", n), v[n].b, v[n].w, v[n].win, v[n].gc, v[n].go);
      @(negedge clk);
      chk($sformatf("vec%0d.pulse_end", n), 32'(result_valid), 32'd0);
    end

    // Game over: guess load and scoring are locked out.
    load_pegs(1'b0, 12'o7777);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      compare = 1'b1;
      ci = 2'(i);
    end
    @(negedge clk);
    compare = 1'b0;
    reach = 1'b1;
    @(negedge clk);
    reach = 1'b0;
    chk("locked.result_valid", 32'(result_valid), 32'd0);
    chk_outs("locked", 3'd0, 3'd4, 1'b0, 4'd8, 1'b1);

    // load_code_1 restarts the game; code peg 0 reloaded with the same colour.
    @(negedge clk);
    data_in = 3'd1;
    lc = 4'b0001;
    @(negedge clk);
    lc = '0;
    chk_outs("restart", 3'd0, 3'd4, 1'b0, 4'd0, 1'b0);
    score();
    chk_outs("kept_guess", 3'd0, 3'd4, 1'b0, 4'd1, 1'b0);

    // Asynchronous reset in the middle of a pass.
    load_pegs(1'b0, 12'o1234);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compare = 1'b1;
      ci = 2'(i);
    end
    #2 resetn = 1'b0;
    #1;
    chk_outs("async_rst", 3'd0, 3'd0, 1'b0, 4'd0, 1'b0);
    chk("async_rst.result_valid", 32'(result_valid), 32'd0);
    @(negedge clk);
    compare = 1'b0;
    resetn = 1'b1;
    load_pegs(1'b1, 12'o1234);
    load_pegs(1'b0, 12'o1243);
    score();
    chk_outs("after_rst", 3'd2, 3'd2, 1'b0, 4'd1, 1'b0);

    // Compare of index 3 coinciding with finalise is left out of the result.
    load_pegs(1'b0, 12'o1244);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compare = 1'b1;
      ci = 2'(i);
    end
    @(negedge clk);
    ci = 2'd3;
    reach = 1'b1;
    @(negedge clk);
    compare = 1'b0;
    reach = 1'b0;
    chk("overlap.result_valid", 32'(result_valid), 32'd1);
    chk_outs("overlap", 3'd2, 3'd0, 1'b0, 4'd2, 1'b0);
    @(negedge clk);
    chk("overlap.pulse_end", 32'(result_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
